mdu_seq: RTL and testbench

Sequential multiply/divide unit for the MIPS150 datapath, parametrised in operand width. It runs MULT, MULTU, DIV and DIVU as multi-cycle radix-2 operations and owns the architectural HI/LO registers. It also executes MTHI and MTLO. It sits beside the combinational ALU in the execute stage; the control unit stalls the pipeline while Busy is high.

---
 rtl/mdu_seq_pkg.sv | 38 +++
 rtl/mdu_step.sv | 51 +++++
 rtl/mdu_seq.sv | 190 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: command
// codes, FSM state encoding and small command-classification helpers.
package mdu_seq_pkg;

    // Command codes driven by the ALU decoder.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // True for the four multi-cycle arithmetic commands.
    function automatic logic op_is_arith(logic [2:0] code);
        return (code == MDU_MULT) || (code == MDU_MULTU) ||
               (code == MDU_DIV)  || (code == MDU_DIVU);
    endfunction

    // True for commands that interpret operands as two's complement.
    function automatic logic op_is_signed(logic [2:0] code);
        return (code == MDU_MULT) || (code == MDU_DIV);
    endfunction

    // True for the divide commands.
    function automatic logic op_is_div(logic [2:0] code);
        return (code == MDU_DIV) || (code == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// The 2*WIDTH accumulator is {upper, lower}:
//   multiply: upper = partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits
// For divide the vacated LSB of acc_o is left zero and the new quotient bit
// is reported separately on q_bit_o; the caller merges it.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    // Compute both the shift-add and the restoring-subtract step, then select.
    always_comb begin
        // NOTE: every variable gets a value on every path, so no latch is inferred.
        upper    = acc_i[2*WIDTH-1:WIDTH];
        lower    = acc_i[WIDTH-1:0];

        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, keep the carry, and shift the whole accumulator right by one.
        sum      = {1'b0, upper} + (lower[0] ? {1'b0, opnd_i} : '0);

        // Restoring divide: bring down the next dividend bit into a WIDTH+1
        // bit partial remainder and subtract the divisor when it fits.
        shifted  = {upper, lower[WIDTH-1]};
        diff     = shifted - {1'b0, opnd_i};
        fits     = (shifted >= {1'b0, opnd_i});
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

        if (is_div_i) begin
            acc_o   = {rem_next, lower[WIDTH-2:0], 1'b0};
            q_bit_o = fits;
        end else begin
            acc_o   = {sum, lower[WIDTH-1:1]};
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit. Runs MULT/MULTU/DIV/DIVU as WIDTH
// radix-2 iterations followed by one sign-fixup cycle, and owns the
// architectural HI/LO registers (also written directly by MTHI/MTLO).
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       MDUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mdu_state_e         state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   opnd_q,   opnd_d;
    mdu_op_e            op_q,     op_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic               b_sign_q, b_sign_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               done_q,   done_d;

    // Operand magnitudes presented at load time.
    logic               load_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Sign-fixup view of the finished accumulator.
    logic               fix_signed;
    logic               fix_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Single-iteration datapath.
    logic               step_is_div;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q_bit;

    assign load_signed = op_is_signed(MDUop);
    assign a_mag       = (load_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag       = (load_signed && B[WIDTH-1]) ? -B : B;

    // Product and quotient flip sign when operand signs differ; the
    // remainder follows the dividend. Most-negative / -1 wraps to itself.
    assign fix_signed  = op_is_signed(op_q);
    assign fix_neg     = fix_signed && (a_q[WIDTH-1] ^ b_sign_q);
    assign prod_fix    = fix_neg ? -acc_q : acc_q;
    assign quo_fix     = fix_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix     = (fix_signed && a_q[WIDTH-1]) ? -acc_q[2*WIDTH-1:WIDTH]
                                                      :  acc_q[2*WIDTH-1:WIDTH];

    assign step_is_div = op_is_div(op_q);

    mdu_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (step_is_div),
        .acc_o    (step_acc),
        .q_bit_o  (step_q_bit)
    );

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            state_q <= state_d;
        end
    end

    // Next-state logic: one pass of WIDTH iterations, then a single fixup cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start && op_is_arith(MDUop)) state_d = ST_CALC;
            ST_CALC: if (cnt_q == LAST_ITER)          state_d = ST_FIX;
            ST_FIX:                                   state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // Outputs: Busy covers CALC and FIX; Done and HI/LO come straight from flops.
    always_comb begin
        Busy = (state_q != ST_IDLE);
        Done = done_q;
        HI   = hi_q;
        LO   = lo_q;
    end

    // Datapath next values: operand load, iteration, sign fixup, HI/LO writes.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        a_d      = a_q;
        b_sign_d = b_sign_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (MDUop)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            // Multiply is commutative, so both kinds load
                            // |A| into the low half and |B| as the operand.
                            op_d     = mdu_op_e'(MDUop);
                            a_d      = A;
                            b_sign_d = B[WIDTH-1];
                            b_zero_d = (B == '0);
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            opnd_d   = b_mag;
                            cnt_d    = '0;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default:  ;
                    endcase
                end
            end
            ST_CALC: begin
                acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};
                cnt_d = cnt_q + CW'(1);
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (!op_is_div(op_q)) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    // Divide by zero reports the raw dividend regardless of sign.
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    // Datapath and architectural registers; reset aborts any operation.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_sign_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_sign_q <= b_sign_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq at WIDTH = 32, 8 and 16. Expected results
// come from directed constants or from an integer-arithmetic reference model.
module tb_mdu_seq;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st32, st8, st16;
    logic [2:0]  op32, op8, op16;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy32, busy8, busy16;
    logic        done32, done8, done16;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mhi [3];
    logic [31:0] mlo [3];

    mdu_seq #(.WIDTH(32)) u_mdu32 (
        .Clock(clk), .Reset_n(rst_n), .Start(st32), .MDUop(op32), .A(a32), .B(b32),
        .Busy(busy32), .Done(done32), .HI(hi32), .LO(lo32));

    mdu_seq #(.WIDTH(8)) u_mdu8 (
        .Clock(clk), .Reset_n(rst_n), .Start(st8), .MDUop(op8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .HI(hi8), .LO(lo8));

    mdu_seq #(.WIDTH(16)) u_mdu16 (
        .Clock(clk), .Reset_n(rst_n), .Start(st16), .MDUop(op16), .A(a16), .B(b16),
        .Busy(busy16), .Done(done16), .HI(hi16), .LO(lo16));

    function automatic int width_of(int k);
        case (k)
            1:       return 8;
            2:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic get_busy(int k);
        case (k)
            1:       return busy8;
            2:       return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic logic get_done(int k);
        case (k)
            1:       return done8;
            2:       return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic [31:0] get_hi(int k);
        case (k)
            1:       return {24'd0, hi8};
            2:       return {16'd0, hi16};
            default: return hi32;
        endcase
    endfunction

    function automatic logic [31:0] get_lo(int k);
        case (k)
            1:       return {24'd0, lo8};
            2:       return {16'd0, lo16};
            default: return lo32;
        endcase
    endfunction

    task automatic set_in(int k, logic s, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (k)
            1: begin st8  = s; op8  = op; a8  = a[7:0];  b8  = b[7:0];  end
            2: begin st16 = s; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
            default: begin st32 = s; op32 = op; a32 = a; b32 = b; end
        endcase
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w.
    function automatic void ref_model(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] mask, ua, ub, u;
        longint      sa, sb, sq, sr;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua[w-1]) sa = sa - longint'(64'd1 << w);
        if (ub[w-1]) sb = sb - longint'(64'd1 << w);
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT, OP_MULTU: begin
                if (op == OP_MULT) u = 64'(sa * sb);
                else               u = ua * ub;
                hi = 32'((u >> w) & mask);
                lo = 32'(u & mask);
            end
            OP_DIV, OP_DIVU: begin
                if (ub == 64'd0) begin
                    hi = 32'(ua);
                    lo = 32'(mask);
                end else if (op == OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    u  = 64'(sq);
                    lo = 32'(u & mask);
                    u  = 64'(sr);
                    hi = 32'(u & mask);
                end else begin
                    lo = 32'((ua / ub) & mask);
                    hi = 32'((ua % ub) & mask);
                end
            end
            default: ;
        endcase
    endfunction

    // Caller is at a falling edge; Start is driven in this cycle (cycle 0).
    // Returns at the falling edge of the Done cycle, so the next op is back-to-back.
    task automatic do_op(int k, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp_hi, logic [31:0] exp_lo, int intrude, string tag);
        int          w, cyc;
        logic        busy_bad, hilo_moved;
        logic [31:0] hi0, lo0;
        w = width_of(k);
        set_in(k, 1'b1, op, a, b);
        @(negedge clk);
        cyc        = 1;
        busy_bad   = 1'b0;
        hilo_moved = 1'b0;
        hi0        = get_hi(k);
        lo0        = get_lo(k);
        while (get_done(k) !== 1'b1 && cyc < w + 8) begin
            if (get_busy(k) !== 1'b1) busy_bad = 1'b1;
            if (get_hi(k) !== hi0 || get_lo(k) !== lo0) hilo_moved = 1'b1;
            if (cyc == intrude) set_in(k, 1'b1, OP_MTHI, $urandom, $urandom);
            else                set_in(k, 1'b0, op, $urandom, $urandom);
            @(negedge clk);
            cyc++;
        end
        set_in(k, 1'b0, op, a, b);
        check({tag, " done_cycle"}, 64'(cyc), 64'(w + 2));
        check({tag, " busy_through"}, 64'(busy_bad), 64'd0);
        check({tag, " hilo_stable"}, 64'(hilo_moved), 64'd0);
        check({tag, " busy_in_done"}, 64'(get_busy(k)), 64'd0);
        check({tag, " hi"}, 64'(get_hi(k)), 64'(exp_hi));
        check({tag, " lo"}, 64'(get_lo(k)), 64'(exp_lo));
    endtask

    function automatic logic [31:0] pick(int w);
        logic [31:0] m;
        m = mask_of(w);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1;
            3:       return 32'd1 << (w - 1);
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom & m;
        endcase
    endfunction

    task automatic run_random(int k, int n);
        int          w;
        logic [2:0]  op;
        logic [31:0] a, b, eh, el, m;
        w = width_of(k);
        m = mask_of(w);
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick(w);
            b  = pick(w);
            if (op <= OP_DIVU) begin
                ref_model(w, op, a, b, eh, el);
                do_op(k, op, a, b, eh, el, -1, $sformatf("rand_w%0d_%0d op%0d", w, i, op));
                mhi[k] = eh;
                mlo[k] = el;
            end else begin
                set_in(k, 1'b1, op, a, b);
                @(negedge clk);
                set_in(k, 1'b0, op, a, b);
                if (op == OP_MTHI) mhi[k] = a & m;
                if (op == OP_MTLO) mlo[k] = a & m;
                check($sformatf("rand_w%0d_%0d op%0d hi", w, i, op), 64'(get_hi(k)), 64'(mhi[k]));
                check($sformatf("rand_w%0d_%0d op%0d lo", w, i, op), 64'(get_lo(k)), 64'(mlo[k]));
                check($sformatf("rand_w%0d_%0d op%0d busy", w, i, op), 64'(get_busy(k)), 64'd0);
                check($sformatf("rand_w%0d_%0d op%0d done", w, i, op), 64'(get_done(k)), 64'd0);
            end
        end
    endtask

    initial begin
        logic done_seen;
        for (int k = 0; k < 3; k++) begin
            set_in(k, 1'b0, OP_MULT, 32'd0, 32'd0);
            mhi[k] = '0;
            mlo[k] = '0;
        end

        // Reset state of every instance.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_w%0d busy", width_of(k)), 64'(get_busy(k)), 64'd0);
            check($sformatf("reset_w%0d done", width_of(k)), 64'(get_done(k)), 64'd0);
            check($sformatf("reset_w%0d hi", width_of(k)), 64'(get_hi(k)), 64'd0);
            check($sformatf("reset_w%0d lo", width_of(k)), 64'(get_lo(k)), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, issued back-to-back at WIDTH = 32.
        do_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, "multu_max");
        do_op(0, OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, "mult_neg");
        do_op(0, OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, "div_neg");
        do_op(0, OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, -1, "divu_zero");
        do_op(0, OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, -1, "div_zero_neg");
        do_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1, "div_ovf");

        // MTLO in the Done cycle: visible next cycle, no Busy, no Done.
        set_in(0, 1'b1, OP_MTLO, 32'h0000_1234, 32'd0);
        @(negedge clk);
        set_in(0, 1'b0, OP_MULT, 32'd0, 32'd0);
        check("mtlo lo", 64'(lo32), 64'h1234);
        check("mtlo hi", 64'(hi32), 64'h0);
        check("mtlo busy", 64'(busy32), 64'd0);
        check("mtlo done", 64'(done32), 64'd0);

        // A Start (MTHI) arriving in cycle 5 of a DIVU is ignored.
        do_op(0, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, "divu_intrude");

        // Reset in cycle 10 of a MULT aborts at once; no Done follows.
        set_in(0, 1'b1, OP_MULT, 32'd12345, 32'd678);
        @(negedge clk);
        set_in(0, 1'b0, OP_MULT, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort hi", 64'(hi32), 64'd0);
        check("abort lo", 64'(lo32), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32 !== 1'b0) done_seen = 1'b1;
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        check("abort idle", 64'(busy32), 64'd0);
        for (int k = 0; k < 3; k++) begin
            mhi[k] = '0;
            mlo[k] = '0;
        end

        // Randomised operations against the reference model.
        run_random(0, 500);
        run_random(1, 150);
        run_random(2, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
